multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle sequencer for the MIPS-subset datapath. It replaces the single-cycle opcode decoder with a Moore state machine that steps each instruction through fetch, decode, execute, memory and writeback over several clocks. This lets one ALU and one unified memory port be shared across phases. It sits between the instruction register (opcode/funct inputs) and the datapath muxes, register file, PC and memory, and waits on a ready handshake from memory.

## Interface
- No parameters; state and ALU encodings come from the shared include.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `opcode` in 6: IR[31:26]; stable from DECODE onward.
- `funct` in 6: IR[5:0]; used for R-type and jr.
- `zero` in 1: ALU zero flag, valid in BRANCH.
- `mem_ready` in 1: memory completes the current access this cycle.
- `pc_write` out 1: load the PC.
- `pc_source` out 2: PC source select.
  - 00: ALU result.
  - 01: ALUOut (branch target).
  - 10: jump target.
  - 11: rs (jr).
- `i_or_d` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `mem_read`, `mem_write` out 1 each: memory request.
- `ir_write` out 1: load the IR.
- `reg_dst` out 2: register destination select; 00 rt, 01 rd, 10 $ra.
- `mem_to_reg` out 1: register write data select; 1 = MDR.
- `reg_write` out 1: register file write enable.
- `alu_src_a` out 1: ALU A select; 0 = PC, 1 = rs.
- `alu_src_b` out 2: ALU B select.
  - 00: rt.
  - 01: constant 4.
  - 10: extended imm.
  - 11: sign-ext imm<<2.
- `alu_op` out 5: ALU operation code.
- `is_jal` out 1: selects PC as write data.
- `is_signed` out 1: immediate extension; 1 = sign-extend.
- `instr_done` out 1: one-cycle pulse in the final state of each instruction.
- `illegal` out 1: sticky, unsupported opcode seen.
- `state` out 4: current state, for debug.

## Operation
- States: FETCH, DECODE, EXEC_R, R_WB, JR, EXEC_I, I_WB, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP, ILLEGAL.
- All outputs are decoded from the state register plus the latched opcode/funct. Any signal not listed for a state is 0. `is_signed` defaults to 1.
- FETCH:
  - Drives `i_or_d`=0, `mem_read`=1, `alu_src_a`=0, `alu_src_b`=01, ALU_ADD.
  - Holds while `mem_ready`=0.
  - On `mem_ready`=1: `ir_write`=1, `pc_write`=1 with `pc_source`=00, then go to DECODE.
- DECODE: `alu_src_a`=0, `alu_src_b`=11, ALU_ADD (precomputes the branch target into ALUOut). Dispatch by opcode:
  - 000000: JR if funct=001000, otherwise EXEC_R.
  - 001000/001010/001011/001100/001101/001110/001111: EXEC_I.
  - 100011/101011: MEM_ADDR.
  - 000100/000101: BRANCH.
  - 000010/000011: JUMP.
  - Anything else: ILLEGAL.
- EXEC_R: `alu_src_a`=1, `alu_src_b`=00, ALU_FUNCT, then R_WB.
- R_WB: `reg_dst`=01, `reg_write`=1, done.
- JR: `pc_source`=11, `pc_write`=1, done.
- EXEC_I: `alu_src_a`=1, `alu_src_b`=10, then I_WB.
  - ALU op by instruction: addi→ADD, slti→SLT, sltiu→SLTU, andi→AND, ori→OR, xori→XOR, lui→LUI.
  - `is_signed`=0 for andi, ori, xori, lui and sltiu.
- I_WB: `reg_dst`=00, `reg_write`=1, done.
- MEM_ADDR: `alu_src_a`=1, `alu_src_b`=10, ALU_ADD; next MEM_RD for lw, MEM_WR for sw.
- MEM_RD: `i_or_d`=1, `mem_read`=1; holds until `mem_ready`, then MEM_WB.
- MEM_WB: `mem_to_reg`=1, `reg_dst`=00, `reg_write`=1, done.
- MEM_WR: `i_or_d`=1, `mem_write`=1; holds until `mem_ready`, then done.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, ALU_SUB, `pc_source`=01, `pc_write` = `zero` XOR (opcode==000101); done.
- JUMP: `pc_source`=10, `pc_write`=1, done. For jal also `reg_dst`=10, `reg_write`=1, `is_jal`=1 (the PC already holds PC+4).
- ILLEGAL: sets `illegal`, no register or memory write, done.
- After every done state, return to FETCH.

## Timing
- Reset (async, while `rst_n`=0):
  - State = FETCH, `illegal`=0.
  - All write enables, `mem_read`, `mem_write`, `ir_write`, `pc_write` and `instr_done` forced to 0.
  - Reset asserted mid-access abandons the access with no write.
- `mem_ready` is sampled only in FETCH, MEM_RD and MEM_WR; it is ignored elsewhere.
- `mem_ready`=1 in the first cycle of a request completes it that cycle (zero wait). Each extra wait cycle adds exactly one clock.
- Zero-wait cycle counts, FETCH to done inclusive:
  - lw: 5.
  - sw, R-type, I-type: 4.
  - beq/bne, j, jal, jr, illegal: 3.
- `instr_done` is high exactly one cycle per instruction and never in consecutive cycles.
- `illegal` stays set until reset.

## Structure
- Shared include `mc_ctrl_defs.vh` holds:
  - State encodings (4-bit).
  - Opcode constants.
  - FUNCT_JR.
  - ALU codes: ADD=0, SUB=1, FUNCT=2, SLT=3, SLTU=4, AND=5, OR=6, XOR=7, LUI=8.
- Sub-module `mc_decode` is combinational: opcode/funct in; instruction class, I-type `alu_op` and `is_signed` out. The FSM uses it for both dispatch and output decode.

## Test plan
- **lw, zero wait.** opcode 100011, `mem_ready` tied 1. Required sequence: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB. `reg_write` and `mem_to_reg` high only in cycle 5; `instr_done` in cycle 5.
- **sw with waits.** opcode 101011, `mem_ready` low for 2 cycles in FETCH and 3 in MEM_WR. Required: `mem_write` high for 4 cycles, `i_or_d`=1 throughout, done at cycle 9, `reg_write` never asserted.
- **Branches.** beq with `zero`=1 gives `pc_write`=1 and `pc_source`=01 in cycle 3. beq with `zero`=0 gives `pc_write`=0. bne with `zero`=0 gives `pc_write`=1.
- **Jumps and jr.** jal: cycle 3 has `reg_dst`=10, `reg_write`=1, `is_jal`=1, `pc_source`=10. j: no `reg_write`. R-type with funct 001000: JR with `pc_source`=11.
- **I-type ops.** ori (001101): EXEC_I with `alu_op`=6, `is_signed`=0, then I_WB with `reg_dst`=00. addi: `alu_op`=0, `is_signed`=1.
- **Illegal opcode and reset.** opcode 111111: ILLEGAL, `illegal`=1 sticky, no writes, FETCH next. Drop `rst_n` during MEM_RD: outputs are 0 immediately, state is FETCH, `illegal` cleared.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset sequencer: states,
// instruction classes, opcode/funct constants and ALU operation codes.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_R_WB     = 4'd3,
    S_JR       = 4'd4,
    S_EXEC_I   = 4'd5,
    S_I_WB     = 4'd6,
    S_MEM_ADDR = 4'd7,
    S_MEM_RD   = 4'd8,
    S_MEM_WB   = 4'd9,
    S_MEM_WR   = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12,
    S_ILLEGAL  = 4'd13
  } state_e;

  // Instruction class produced by the decoder, used for dispatch.
  typedef enum logic [2:0] {
    CL_R   = 3'd0,
    CL_JR  = 3'd1,
    CL_I   = 3'd2,
    CL_MEM = 3'd3,
    CL_BR  = 3'd4,
    CL_J   = 3'd5,
    CL_ILL = 3'd6
  } iclass_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FUNCT_JR = 6'b001000;

  localparam logic [4:0] ALU_ADD   = 5'd0;
  localparam logic [4:0] ALU_SUB   = 5'd1;
  localparam logic [4:0] ALU_FUNCT = 5'd2;
  localparam logic [4:0] ALU_SLT   = 5'd3;
  localparam logic [4:0] ALU_SLTU  = 5'd4;
  localparam logic [4:0] ALU_AND   = 5'd5;
  localparam logic [4:0] ALU_OR    = 5'd6;
  localparam logic [4:0] ALU_XOR   = 5'd7;
  localparam logic [4:0] ALU_LUI   = 5'd8;

endpackage

// File: rtl/multicycle_control_decode.sv
// Combinational opcode/funct decoder: instruction class for dispatch plus
// the I-type ALU operation and immediate extension mode.
module multicycle_control_decode
  import multicycle_control_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output logic [2:0] iclass_o,
  output logic [4:0] alu_op_o,
  output logic       is_signed_o
);

  // Class and I-type controls; unknown opcodes fall through to CL_ILL.
  always_comb begin
    iclass_o    = CL_ILL;
    alu_op_o    = ALU_ADD;
    is_signed_o = 1'b1;
    case (opcode_i)
      OP_RTYPE: iclass_o = (funct_i == FUNCT_JR) ? CL_JR : CL_R;
      OP_ADDI:  iclass_o = CL_I;
      OP_SLTI:  begin iclass_o = CL_I; alu_op_o = ALU_SLT; end
      OP_SLTIU: begin iclass_o = CL_I; alu_op_o = ALU_SLTU; is_signed_o = 1'b0; end
      OP_ANDI:  begin iclass_o = CL_I; alu_op_o = ALU_AND;  is_signed_o = 1'b0; end
      OP_ORI:   begin iclass_o = CL_I; alu_op_o = ALU_OR;   is_signed_o = 1'b0; end
      OP_XORI:  begin iclass_o = CL_I; alu_op_o = ALU_XOR;  is_signed_o = 1'b0; end
      OP_LUI:   begin iclass_o = CL_I; alu_op_o = ALU_LUI;  is_signed_o = 1'b0; end
      OP_LW,
      OP_SW:    iclass_o = CL_MEM;
      OP_BEQ,
      OP_BNE:   iclass_o = CL_BR;
      OP_J,
      OP_JAL:   iclass_o = CL_J;
      default:  ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle sequencer for the MIPS-subset datapath. Steps each instruction
// through fetch/decode/execute/memory/writeback, sharing one ALU and one
// memory port. Controls are decoded from the state register and the opcode
// latched in DECODE; FETCH, MEM_WR and BRANCH also look at mem_ready/zero.
module multicycle_control
  import multicycle_control_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic [1:0] pc_source,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [4:0] alu_op,
  output logic       is_jal,
  output logic       is_signed,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  state_e     state_q;
  logic [5:0] opcode_q;
  logic       illegal_q;

  logic [5:0] dec_opcode;
  logic [2:0] dec_cls;
  logic [4:0] dec_alu_op;
  logic       dec_is_signed;

  // In DECODE the IR is fresh, so dispatch on the live opcode; afterwards
  // the latched copy drives the output decode.
  assign dec_opcode = (state_q == S_DECODE) ? opcode : opcode_q;

  multicycle_control_decode u_decode (
    .opcode_i    (dec_opcode),
    .funct_i     (funct),
    .iclass_o    (dec_cls),
    .alu_op_o    (dec_alu_op),
    .is_signed_o (dec_is_signed)
  );

  // State sequencing, opcode capture and sticky illegal flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      opcode_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH:    if (mem_ready) state_q <= S_DECODE;
        S_DECODE: begin
          opcode_q <= opcode;
          case (dec_cls)
            CL_R:    state_q <= S_EXEC_R;
            CL_JR:   state_q <= S_JR;
            CL_I:    state_q <= S_EXEC_I;
            CL_MEM:  state_q <= S_MEM_ADDR;
            CL_BR:   state_q <= S_BRANCH;
            CL_J:    state_q <= S_JUMP;
            default: state_q <= S_ILLEGAL;
          endcase
        end
        S_EXEC_R:   state_q <= S_R_WB;
        S_EXEC_I:   state_q <= S_I_WB;
        S_MEM_ADDR: state_q <= (opcode_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD:   if (mem_ready) state_q <= S_MEM_WB;
        S_MEM_WR:   if (mem_ready) state_q <= S_FETCH;
        S_ILLEGAL: begin
          illegal_q <= 1'b1;
          state_q   <= S_FETCH;
        end
        // R_WB, JR, I_WB, MEM_WB, BRANCH, JUMP all finish in one cycle.
        default:    state_q <= S_FETCH;
      endcase
    end
  end

  // Per-state datapath controls; reset masks every request and write strobe
  // so an access in flight is dropped the moment rst_n falls.
  always_comb begin
    pc_write   = 1'b0;
    pc_source  = 2'b00;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 2'b00;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = ALU_ADD;
    is_jal     = 1'b0;
    is_signed  = 1'b1;
    instr_done = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE:   alu_src_b = 2'b11;
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        reg_dst    = 2'b01;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_JR: begin
        pc_source  = 2'b11;
        pc_write   = 1'b1;
        instr_done = 1'b1;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = dec_alu_op;
        is_signed = dec_is_signed;
      end
      S_I_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        i_or_d   = 1'b1;
        mem_read = 1'b1;
      end
      S_MEM_WB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WR: begin
        i_or_d     = 1'b1;
        mem_write  = 1'b1;
        instr_done = mem_ready;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = ALU_SUB;
        pc_source  = 2'b01;
        pc_write   = zero ^ (opcode_q == OP_BNE);
        instr_done = 1'b1;
      end
      S_JUMP: begin
        pc_source  = 2'b10;
        pc_write   = 1'b1;
        instr_done = 1'b1;
        if (opcode_q == OP_JAL) begin
          reg_dst   = 2'b10;
          reg_write = 1'b1;
          is_jal    = 1'b1;
        end
      end
      S_ILLEGAL:  instr_done = 1'b1;
      default:    ;
    endcase
    if (!rst_n) begin
      pc_write   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      instr_done = 1'b0;
    end
  end

  assign illegal = illegal_q | (state_q == S_ILLEGAL);
  assign state   = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control. For each instruction the bench
// derives the expected state walk and per-instruction control totals from
// the instruction class and the wait counts it chose, then compares.
module tb_multicycle_control;
  import multicycle_control_pkg::*;

  logic       clk, rst_n;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       pc_write, i_or_d, mem_read, mem_write, ir_write, mem_to_reg;
  logic       reg_write, alu_src_a, is_jal, is_signed, instr_done, illegal;
  logic [1:0] pc_source, reg_dst, alu_src_b;
  logic [4:0] alu_op;
  logic [3:0] state;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .pc_source(pc_source),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .is_jal(is_jal), .is_signed(is_signed),
    .instr_done(instr_done), .illegal(illegal), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum {K_R, K_JR, K_I, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_JAL, K_ILL} kind_e;

  int n_chk  = 0;
  int n_pass = 0;
  bit ill_seen = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic kind_e classify(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'b000000: return (fn == 6'b001000) ? K_JR : K_R;
      6'b001000, 6'b001010, 6'b001011, 6'b001100,
      6'b001101, 6'b001110, 6'b001111: return K_I;
      6'b100011: return K_LW;
      6'b101011: return K_SW;
      6'b000100: return K_BEQ;
      6'b000101: return K_BNE;
      6'b000010: return K_J;
      6'b000011: return K_JAL;
      default:   return K_ILL;
    endcase
  endfunction

  // I-type ALU code and extension mode straight from the instruction table.
  function automatic logic [5:0] itype_ctl(input logic [5:0] op);
    case (op)
      6'b001000: return {5'd0, 1'b1};  // addi
      6'b001010: return {5'd3, 1'b1};  // slti
      6'b001011: return {5'd4, 1'b0};  // sltiu
      6'b001100: return {5'd5, 1'b0};  // andi
      6'b001101: return {5'd6, 1'b0};  // ori
      6'b001110: return {5'd7, 1'b0};  // xori
      default:   return {5'd8, 1'b0};  // lui
    endcase
  endfunction

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int wf, input int wm, input logic zr);
    kind_e  k;
    state_e seq[$];
    int n_rw, n_mr, n_mw, n_pw, n_irw, addr_err, fetch_pcs_err;
    logic [1:0] rw_dst, pcs;
    logic mtr, jl, last, exp_pw, writes;
    logic [5:0] ictl;
    k = classify(op, fn);
    n_rw = 0; n_mr = 0; n_mw = 0; n_pw = 0; n_irw = 0; addr_err = 0; fetch_pcs_err = 0;
    rw_dst = 2'b11; pcs = 2'b00; mtr = 1'b0; jl = 1'b0;
    for (int i = 0; i <= wf; i++) seq.push_back(S_FETCH);
    seq.push_back(S_DECODE);
    case (k)
      K_R:   begin seq.push_back(S_EXEC_R); seq.push_back(S_R_WB); end
      K_JR:  seq.push_back(S_JR);
      K_I:   begin seq.push_back(S_EXEC_I); seq.push_back(S_I_WB); end
      K_LW:  begin
        seq.push_back(S_MEM_ADDR);
        for (int i = 0; i <= wm; i++) seq.push_back(S_MEM_RD);
        seq.push_back(S_MEM_WB);
      end
      K_SW:  begin
        seq.push_back(S_MEM_ADDR);
        for (int i = 0; i <= wm; i++) seq.push_back(S_MEM_WR);
      end
      K_BEQ, K_BNE: seq.push_back(S_BRANCH);
      K_J, K_JAL:   seq.push_back(S_JUMP);
      default:      seq.push_back(S_ILLEGAL);
    endcase
    for (int c = 0; c < seq.size(); c++) begin
      @(negedge clk);
      last = (c == seq.size() - 1) || (seq[c+1] != seq[c]);
      if (seq[c] == S_FETCH || seq[c] == S_MEM_RD || seq[c] == S_MEM_WR)
        mem_ready = last;
      else
        mem_ready = 1'($urandom);
      opcode = (seq[c] == S_FETCH) ? 6'($urandom) : op;
      funct  = (seq[c] == S_FETCH) ? 6'($urandom) : fn;
      zero   = (seq[c] == S_BRANCH) ? zr : 1'($urandom);
      #1;
      chk("state", 32'(state), 32'(seq[c]));
      chk("instr_done", 32'(instr_done), 32'(c == seq.size() - 1));
      chk("illegal", 32'(illegal), 32'(ill_seen || (k == K_ILL && seq[c] == S_ILLEGAL)));
      if (reg_write) begin n_rw++; rw_dst = reg_dst; mtr = mem_to_reg; jl = is_jal; end
      if (mem_read) n_mr++;
      if (mem_write) n_mw++;
      if ((mem_read || mem_write) && (i_or_d != (seq[c] != S_FETCH))) addr_err++;
      if (ir_write) n_irw++;
      if (pc_write) begin
        n_pw++;
        if (seq[c] == S_FETCH) begin if (pc_source != 2'b00) fetch_pcs_err++; end
        else pcs = pc_source;
      end
      if (seq[c] == S_EXEC_I) begin
        ictl = itype_ctl(op);
        chk("i_alu_op", 32'(alu_op), 32'(ictl[5:1]));
        chk("i_is_signed", 32'(is_signed), 32'(ictl[0]));
        chk("i_alu_src_b", 32'(alu_src_b), 32'd2);
      end
      if (seq[c] == S_EXEC_R) chk("r_alu_op", 32'(alu_op), 32'd2);
      if (seq[c] == S_BRANCH) begin
        chk("br_alu_op", 32'(alu_op), 32'd1);
        chk("br_pc_source", 32'(pc_source), 32'd1);
      end
    end
    if (k == K_ILL) ill_seen = 1'b1;
    exp_pw = (k == K_JR || k == K_J || k == K_JAL) ||
             (k == K_BEQ && zr) || (k == K_BNE && !zr);
    writes = (k == K_R || k == K_I || k == K_LW || k == K_JAL);
    chk("ir_write_cnt", 32'(n_irw), 32'd1);
    chk("pc_write_cnt", 32'(n_pw), 32'(1 + 32'(exp_pw)));
    chk("mem_read_cnt", 32'(n_mr), 32'(wf + 1 + ((k == K_LW) ? wm + 1 : 0)));
    chk("mem_write_cnt", 32'(n_mw), 32'((k == K_SW) ? wm + 1 : 0));
    chk("reg_write_cnt", 32'(n_rw), 32'(writes));
    chk("i_or_d_err", 32'(addr_err), 32'd0);
    chk("fetch_pcs_err", 32'(fetch_pcs_err), 32'd0);
    if (writes) begin
      chk("reg_dst", 32'(rw_dst),
          (k == K_R) ? 32'd1 : (k == K_JAL) ? 32'd2 : 32'd0);
      chk("mem_to_reg", 32'(mtr), 32'(k == K_LW));
      chk("is_jal", 32'(jl), 32'(k == K_JAL));
    end
    if (exp_pw)
      chk("pc_source", 32'(pcs),
          (k == K_JR) ? 32'd3 : (k == K_BEQ || k == K_BNE) ? 32'd1 : 32'd2);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_state"},      32'(state), 32'(S_FETCH));
    chk({tag, "_mem_read"},   32'(mem_read), 32'd0);
    chk({tag, "_mem_write"},  32'(mem_write), 32'd0);
    chk({tag, "_reg_write"},  32'(reg_write), 32'd0);
    chk({tag, "_pc_write"},   32'(pc_write), 32'd0);
    chk({tag, "_ir_write"},   32'(ir_write), 32'd0);
    chk({tag, "_instr_done"}, 32'(instr_done), 32'd0);
    chk({tag, "_illegal"},    32'(illegal), 32'd0);
  endtask

  logic [5:0] legal_ops [14];

  initial begin
    logic [5:0] op, fn;
    legal_ops = '{6'b000000, 6'b001000, 6'b001010, 6'b001011, 6'b001100,
                  6'b001101, 6'b001110, 6'b001111, 6'b100011, 6'b101011,
                  6'b000100, 6'b000101, 6'b000010, 6'b000011};
    rst_n = 1'b0; mem_ready = 1'b1; opcode = '0; funct = '0; zero = 1'b0;
    #2;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    mem_ready = 1'b0;
    rst_n = 1'b1;

    // Directed: spec scenarios first.
    run_instr(6'b100011, 6'd0, 0, 0, 1'b0);        // lw, zero wait
    run_instr(6'b101011, 6'd0, 2, 3, 1'b0);        // sw, 2+3 waits
    run_instr(6'b000100, 6'd0, 0, 0, 1'b1);        // beq taken
    run_instr(6'b000100, 6'd0, 0, 0, 1'b0);        // beq not taken
    run_instr(6'b000101, 6'd0, 0, 0, 1'b0);        // bne taken
    run_instr(6'b000101, 6'd0, 1, 0, 1'b1);        // bne not taken
    run_instr(6'b000011, 6'd0, 0, 0, 1'b0);        // jal
    run_instr(6'b000010, 6'd0, 0, 0, 1'b0);        // j
    run_instr(6'b000000, 6'b001000, 0, 0, 1'b0);   // jr
    run_instr(6'b000000, 6'b100000, 0, 0, 1'b0);   // R-type add
    run_instr(6'b001101, 6'd0, 0, 0, 1'b0);        // ori
    run_instr(6'b001000, 6'd0, 0, 0, 1'b0);        // addi
    run_instr(6'b111111, 6'd0, 0, 0, 1'b0);        // illegal
    run_instr(6'b001011, 6'd0, 0, 0, 1'b0);        // sltiu after illegal

    // Random instruction stream.
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 15) < 14) op = legal_ops[$urandom_range(0, 13)];
      else op = 6'($urandom);
      fn = ($urandom_range(0, 3) == 0) ? 6'b001000 : 6'($urandom);
      run_instr(op, fn, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
    end

    // Reset while a load is waiting in MEM_RD.
    @(negedge clk); opcode = 6'b100011; funct = '0; mem_ready = 1'b1;  // FETCH
    @(negedge clk); mem_ready = 1'b0;                                  // DECODE
    @(negedge clk);                                                    // MEM_ADDR
    @(negedge clk); #1;                                                // MEM_RD
    chk("rd_state", 32'(state), 32'(S_MEM_RD));
    chk("rd_mem_read", 32'(mem_read), 32'd1);
    chk("rd_illegal_sticky", 32'(illegal), 32'(ill_seen));
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk); #1;
    check_reset_outputs("midrst_hold");
    mem_ready = 1'b0;
    rst_n = 1'b1;
    ill_seen = 1'b0;
    run_instr(6'b001000, 6'd0, 1, 0, 1'b0);        // addi after reset
    run_instr(6'b100011, 6'd0, 0, 2, 1'b0);        // lw with waits

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
